// File: rtl/neuron_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// neuron_accumulator_pkg
// Q-format helpers shared by the accumulator and anything else that handles
// fixed-point layer results: default word split, accumulator sizing,
// activation-select encodings, FSM state type and saturation limits.
// -----------------------------------------------------------------------------
package neuron_accumulator_pkg;

  localparam int FIXED_BITS_DEF      = 8;
  localparam int FRACTIONAL_BITS_DEF = 8;
  localparam int MAX_TERMS_DEF       = 16;
  localparam int GUARD_BITS_DEF      = 8;
  localparam int LEAKY_SHIFT_DEF     = 3;

  typedef enum logic [1:0] {
    ACT_IDENTITY = 2'd0,
    ACT_RELU     = 2'd1,
    ACT_LEAKY    = 2'd2,
    ACT_CLAMP    = 2'd3
  } act_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_FINISH = 2'd2,
    ST_HOLD   = 2'd3
  } acc_state_e;

  function automatic int q_width(int fixed_bits, int frac_bits);
    return fixed_bits + frac_bits;
  endfunction

  // Full-precision product is 2W bits; guard bits absorb up to 2^guard terms.
  function automatic int acc_width(int w, int guard_bits);
    return 2 * w + guard_bits;
  endfunction

  // Largest / smallest representable W-bit two's complement word.
  function automatic logic signed [63:0] q_sat_max(int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] q_sat_min(int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/neuron_accumulator_q_sat_act.sv
// -----------------------------------------------------------------------------
// neuron_accumulator_q_sat_act
// Combinational post-processing of a wide fixed-point sum: drop the extra
// fractional bits (floor), saturate to a W-bit Q word and apply the selected
// activation.
//   i_sum      : wide signed sum with 2*FRAC_BITS fractional bits
//   i_act_sel  : activation select (act_sel_e encoding)
//   o_value    : activated W-bit Q-format result
//   o_overflow : the sum did not fit in W bits and was clipped
// -----------------------------------------------------------------------------
module neuron_accumulator_q_sat_act
  import neuron_accumulator_pkg::*;
#(
  parameter int W           = 16,
  parameter int FRAC_BITS   = 8,
  parameter int SUM_W       = 41,
  parameter int LEAKY_SHIFT = 3
) (
  input  logic signed [SUM_W-1:0] i_sum,
  input  logic        [1:0]       i_act_sel,
  output logic signed [W-1:0]     o_value,
  output logic                    o_overflow
);

  localparam logic signed [SUM_W-1:0] SAT_MAX  = SUM_W'(q_sat_max(W));
  localparam logic signed [SUM_W-1:0] SAT_MIN  = SUM_W'(q_sat_min(W));
  localparam logic signed [W-1:0]     CLAMP_HI = W'(64'sd1 <<< FRAC_BITS);
  localparam logic signed [W-1:0]     CLAMP_LO = -CLAMP_HI;

  logic signed [SUM_W-1:0] w_res;
  logic signed [W-1:0]     w_sat;

  // Arithmetic shift gives floor rounding toward minus infinity.
  assign w_res = i_sum >>> FRAC_BITS;

  always_comb begin
    o_overflow = 1'b0;
    w_sat      = w_res[W-1:0];
    if (w_res > SAT_MAX) begin
      w_sat      = SAT_MAX[W-1:0];
      o_overflow = 1'b1;
    end else if (w_res < SAT_MIN) begin
      w_sat      = SAT_MIN[W-1:0];
      o_overflow = 1'b1;
    end
  end

  // Clamp mode limits to +/-1.0 but is a deliberate activation, not an overflow.
  always_comb begin
    o_value = w_sat;
    case (act_sel_e'(i_act_sel))
      ACT_RELU:  if (w_sat[W-1]) o_value = '0;
      ACT_LEAKY: if (w_sat[W-1]) o_value = w_sat >>> LEAKY_SHIFT;
      ACT_CLAMP: begin
        if (w_sat > CLAMP_HI)      o_value = CLAMP_HI;
        else if (w_sat < CLAMP_LO) o_value = CLAMP_LO;
      end
      default:   o_value = w_sat;
    endcase
  end

endmodule

// File: rtl/neuron_accumulator.sv
// -----------------------------------------------------------------------------
// neuron_accumulator
// Sequenced dot-product accumulator for one neuron output. Accepts
// (activation, weight) beats over valid/ready, accumulates full-precision
// products, adds bias, rescales/saturates/activates and presents one result
// per vector over valid/ready.
//   clk, rst_n                 : clock, async active-low reset
//   in_valid/in_ready/in_last  : input beat handshake, end of vector
//   in_value, in_weight        : Q-format activation and weight
//   bias, act_sel              : sampled on the first beat of a vector
//   out_valid/out_ready        : result handshake
//   out_value                  : activated Q-format result
//   out_overflow, out_len_err  : saturation flag, vector cut at MAX_TERMS
//   busy                       : not idle
//
// state  | meaning
// IDLE   | waiting for the first beat of a vector
// ACCUM  | adding products of further beats
// FINISH | one cycle: bias, rescale, saturate, activate, register result
// HOLD   | result presented, waiting for out_ready
// -----------------------------------------------------------------------------
module neuron_accumulator
  import neuron_accumulator_pkg::*;
#(
  parameter int FIXED_BITS      = FIXED_BITS_DEF,
  parameter int FRACTIONAL_BITS = FRACTIONAL_BITS_DEF,
  parameter int MAX_TERMS       = MAX_TERMS_DEF,
  parameter int GUARD_BITS      = GUARD_BITS_DEF,
  parameter int LEAKY_SHIFT     = LEAKY_SHIFT_DEF
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic signed [FIXED_BITS+FRACTIONAL_BITS-1:0]  in_value,
  input  logic signed [FIXED_BITS+FRACTIONAL_BITS-1:0]  in_weight,
  input  logic                                          in_last,
  input  logic signed [FIXED_BITS+FRACTIONAL_BITS-1:0]  bias,
  input  logic        [1:0]                             act_sel,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic signed [FIXED_BITS+FRACTIONAL_BITS-1:0]  out_value,
  output logic                                          out_overflow,
  output logic                                          out_len_err,
  output logic                                          busy
);

  localparam int W     = q_width(FIXED_BITS, FRACTIONAL_BITS);
  localparam int ACC_W = acc_width(W, GUARD_BITS);
  localparam int SUM_W = ACC_W + 1;
  localparam int CNT_W = $clog2(MAX_TERMS) + 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(MAX_TERMS - 1);

  acc_state_e              r_state;
  logic signed [ACC_W-1:0] r_acc;
  logic        [CNT_W-1:0] r_count;
  logic signed [W-1:0]     r_bias;
  logic        [1:0]       r_act_sel;
  logic                    r_len_err;
  logic                    r_in_ready;
  logic                    r_busy;
  logic                    r_out_valid;
  logic signed [W-1:0]     r_out_value;
  logic                    r_out_overflow;
  logic                    r_out_len_err;

  logic                    w_accept;
  logic signed [2*W-1:0]   w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [SUM_W-1:0] w_sum;
  logic signed [W-1:0]     w_act_value;
  logic                    w_overflow;

  assign w_accept = in_valid && r_in_ready;

  // Low 2W bits of the product of sign-extended operands are the exact signed product.
  assign w_prod = $signed({{W{in_value[W-1]}}, in_value}) *
                  $signed({{W{in_weight[W-1]}}, in_weight});
  assign w_prod_ext = {{GUARD_BITS{w_prod[2*W-1]}}, w_prod};

  // Bias is aligned to the product's 2*FRACTIONAL_BITS binary point; one extra
  // bit keeps the bias addition from wrapping.
  assign w_sum = $signed({r_acc[ACC_W-1], r_acc}) +
                 ($signed({{(SUM_W-W){r_bias[W-1]}}, r_bias}) <<< FRACTIONAL_BITS);

  neuron_accumulator_q_sat_act #(
    .W           (W),
    .FRAC_BITS   (FRACTIONAL_BITS),
    .SUM_W       (SUM_W),
    .LEAKY_SHIFT (LEAKY_SHIFT)
  ) u_q_sat_act (
    .i_sum      (w_sum),
    .i_act_sel  (r_act_sel),
    .o_value    (w_act_value),
    .o_overflow (w_overflow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_acc          <= '0;
      r_count        <= '0;
      r_bias         <= '0;
      r_act_sel      <= '0;
      r_len_err      <= 1'b0;
      r_in_ready     <= 1'b0;
      r_busy         <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out_value    <= '0;
      r_out_overflow <= 1'b0;
      r_out_len_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_in_ready <= 1'b1;
          r_busy     <= 1'b0;
          if (w_accept) begin
            r_bias    <= bias;
            r_act_sel <= act_sel;
            r_acc     <= w_prod_ext;
            r_count   <= CNT_W'(1);
            r_len_err <= 1'b0;
            r_busy    <= 1'b1;
            if (in_last) begin
              r_state    <= ST_FINISH;
              r_in_ready <= 1'b0;
            end else begin
              r_state    <= ST_ACCUM;
            end
          end
        end

        ST_ACCUM: begin
          if (w_accept) begin
            r_acc   <= r_acc + w_prod_ext;
            r_count <= r_count + CNT_W'(1);
            // Close on in_last, or force-close on the MAX_TERMS-th beat.
            if (in_last || (r_count == LAST_COUNT)) begin
              r_state    <= ST_FINISH;
              r_in_ready <= 1'b0;
              r_len_err  <= !in_last;
            end
          end
        end

        ST_FINISH: begin
          r_out_value    <= w_act_value;
          r_out_overflow <= w_overflow;
          r_out_len_err  <= r_len_err;
          r_out_valid    <= 1'b1;
          r_state        <= ST_HOLD;
        end

        ST_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_count     <= '0;
            r_len_err   <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end

        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign busy         = r_busy;
  assign out_valid    = r_out_valid;
  assign out_value    = r_out_value;
  assign out_overflow = r_out_overflow;
  assign out_len_err  = r_out_len_err;

endmodule

// File: tb/tb_neuron_accumulator.sv
// -----------------------------------------------------------------------------
// tb_neuron_accumulator
// Directed vectors with hand-computed results, then randomized traffic.
// A behavioural model (integer sums, floor division, clip, activation) runs
// alongside and one compare process checks every DUT output each cycle.
// -----------------------------------------------------------------------------
module tb_neuron_accumulator;

  localparam int MAXT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_value = '0;
  logic [15:0] in_weight = '0;
  logic [15:0] bias = '0;
  logic [1:0]  act_sel = '0;
  logic        in_ready;
  logic        out_valid;
  logic        out_overflow;
  logic        out_len_err;
  logic        busy;
  logic [15:0] out_value;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  neuron_accumulator dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_value     (in_value),
    .in_weight    (in_weight),
    .in_last      (in_last),
    .bias         (bias),
    .act_sel      (act_sel),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_value    (out_value),
    .out_overflow (out_overflow),
    .out_len_err  (out_len_err),
    .busy         (busy)
  );

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural reference ----------------
  function automatic longint res_of(longint acc, logic [15:0] b);
    return (acc + longint'($signed(b)) * 256) >>> 8;
  endfunction

  function automatic bit ovf_of(longint acc, logic [15:0] b);
    longint r;
    r = res_of(acc, b);
    return (r > 32767) || (r < -32768);
  endfunction

  function automatic logic [15:0] val_of(longint acc, logic [15:0] b, logic [1:0] a);
    longint r;
    r = res_of(acc, b);
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    case (a)
      2'd1: if (r < 0) r = 0;
      2'd2: if (r < 0) r = r >>> 3;
      2'd3: begin
        if (r > 256) r = 256;
        else if (r < -256) r = -256;
      end
      default: ;
    endcase
    return r[15:0];
  endfunction

  bit          m_started, m_closing, m_out_valid, m_ovf, m_out_le, m_len_err;
  int          m_cnt;
  longint      m_acc;
  logic [15:0] m_bias, m_out_value;
  logic [1:0]  m_act;
  logic        m_rdy, m_busy;

  assign m_rdy  = m_started && !m_closing && !m_out_valid;
  assign m_busy = (m_cnt != 0) || m_closing || m_out_valid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_started <= 0; m_closing <= 0; m_out_valid <= 0; m_ovf <= 0;
      m_out_le <= 0; m_len_err <= 0; m_cnt <= 0; m_acc <= 0;
      m_bias <= '0; m_act <= '0; m_out_value <= '0;
    end else begin
      m_started <= 1;
      if (m_out_valid && out_ready) m_out_valid <= 0;
      if (m_closing) begin
        m_out_value <= val_of(m_acc, m_bias, m_act);
        m_ovf       <= ovf_of(m_acc, m_bias);
        m_out_le    <= m_len_err;
        m_out_valid <= 1;
        m_closing   <= 0;
        m_cnt       <= 0;
      end else if (m_rdy && in_valid) begin
        if (m_cnt == 0) begin
          m_acc  <= longint'($signed(in_value)) * longint'($signed(in_weight));
          m_bias <= bias;
          m_act  <= act_sel;
        end else begin
          m_acc  <= m_acc + longint'($signed(in_value)) * longint'($signed(in_weight));
        end
        m_cnt <= m_cnt + 1;
        if (in_last || (m_cnt + 1 == MAXT)) begin
          m_closing <= 1;
          m_len_err <= !in_last;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    chk("in_ready",     in_ready,     m_rdy);
    chk("busy",         busy,         m_busy);
    chk("out_valid",    out_valid,    m_out_valid);
    chk("out_value",    out_value,    m_out_value);
    chk("out_overflow", out_overflow, m_ovf);
    chk("out_len_err",  out_len_err,  m_out_le);
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_accept();
    bit ok;
    int n;
    n = 0;
    do begin
      ok = in_ready;
      cyc();
      n++;
    end while (!ok && n < 100);
    chk("beat_accepted", ok, 1);
    in_valid = 1'b0;
  endtask

  task automatic beat(input logic [15:0] v, input logic [15:0] w, input logic l);
    in_valid  = 1'b1;
    in_value  = v;
    in_weight = w;
    in_last   = l;
    wait_accept();
  endtask

  task automatic wait_out(input logic [15:0] ev, input logic eo, input logic el,
                          input int hold, input string nm);
    int n;
    n = 0;
    out_ready = 1'b0;
    while (!out_valid && n < 100) begin
      cyc();
      n++;
    end
    chk({nm, "_latency"}, n, 1);
    chk({nm, "_value"}, out_value, ev);
    chk({nm, "_overflow"}, out_overflow, eo);
    chk({nm, "_len_err"}, out_len_err, el);
    for (int i = 0; i < hold; i++) begin
      cyc();
      chk({nm, "_hold_valid"}, out_valid, 1);
      chk({nm, "_hold_value"}, out_value, ev);
      chk({nm, "_hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk({nm, "_drop_valid"}, out_valid, 0);
    chk({nm, "_ready_again"}, in_ready, 1);
  endtask

  function automatic logic [15:0] rnd_q();
    if ($urandom_range(1) == 0) return 16'($urandom);
    return 16'($urandom_range(2047)) - 16'd1024;
  endfunction

  logic [15:0] leaky_exp [4];

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    cyc();
    chk("reset_out_value", out_value, 0);
    chk("reset_busy", busy, 0);
    chk("reset_in_ready", in_ready, 1);

    // Basic dot product with backpressure: 1.5*2.0 + 0.5*(-1.0) + 0.25 = 2.75
    bias = 16'h0040; act_sel = 2'd0;
    beat(16'h0180, 16'h0200, 1'b0);
    beat(16'h0080, 16'hFF00, 1'b1);
    wait_out(16'h02C0, 1'b0, 1'b0, 5, "basic");

    // Activations on -2.0
    leaky_exp[0] = 16'hFE00; leaky_exp[1] = 16'h0000;
    leaky_exp[2] = 16'hFFC0; leaky_exp[3] = 16'hFF00;
    bias = 16'h0000;
    for (int a = 0; a < 4; a++) begin
      act_sel = 2'(a);
      beat(16'hFE00, 16'h0100, 1'b1);
      wait_out(leaky_exp[a], 1'b0, 1'b0, 0, "act");
    end

    // Saturation both ways
    act_sel = 2'd0;
    beat(16'h7F00, 16'h7F00, 1'b1);
    wait_out(16'h7FFF, 1'b1, 1'b0, 0, "sat_hi");
    beat(16'h8000, 16'h7F00, 1'b1);
    wait_out(16'h8000, 1'b1, 1'b0, 0, "sat_lo");

    // Length limit, 17th beat pending across the handshake
    for (int i = 0; i < MAXT; i++) beat(16'h0100, 16'h0100, 1'b0);
    in_valid = 1'b1; in_value = 16'h0100; in_weight = 16'h0100; in_last = 1'b1;
    wait_out(16'h1000, 1'b0, 1'b1, 2, "len");
    in_valid = 1'b1;
    wait_accept();
    wait_out(16'h0100, 1'b0, 1'b0, 0, "after_len");

    // Reset mid-vector
    for (int i = 0; i < 3; i++) beat(16'h0300, 16'h0100, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_busy", busy, 0);
    cyc(); cyc();
    rst_n = 1'b1;
    beat(16'h0100, 16'h0100, 1'b1);
    wait_out(16'h0100, 1'b0, 1'b0, 0, "post_rst");

    // Reset while holding a result
    beat(16'h0200, 16'h0200, 1'b1);
    cyc();
    chk("hold_before_rst", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_hold_out_valid", out_valid, 0);
    chk("rst_hold_busy", busy, 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_last   = ($urandom_range(5) == 0);
      in_value  = rnd_q();
      in_weight = rnd_q();
      bias      = rnd_q();
      act_sel   = 2'($urandom_range(3));
      out_ready = ($urandom_range(2) != 0);
      cyc();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
